// File: rtl/if_fetch_unit_pkg.sv
// Shared types and default widths for the instruction-fetch front end.
package if_fetch_unit_pkg;

    localparam int IF_PC_WIDTH   = 32;
    localparam int IF_INST_WIDTH = 32;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_RSP  = 2'd2
    } if_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/grant + read-data bus between the fetch unit and memory.
interface if_fetch_unit_if
    import if_fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH   = IF_PC_WIDTH,
    parameter int INST_WIDTH = IF_INST_WIDTH
) ();

    logic                  req;
    logic [PC_WIDTH-1:0]   addr;
    logic                  gnt;
    logic                  rvalid;
    logic [INST_WIDTH-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/if_inst_fifo.sv
// Small fetch buffer: flop array with a combinational head read so a push is visible the next cycle.
module if_inst_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] wr_en;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop   = pop & (count_q != '0);
        // a pop in the same cycle frees the slot, so push-at-full is legal then
        do_push  = push & ((count_q != CNT_W'(DEPTH)) | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
        assign wr_en[gi] = do_push & ~flush & (wr_ptr_q == PTR_W'(gi));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    mem_q[i] <= din;
                end
            end
        end
    end

    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: one outstanding imem request, redirect squash, and a {pc, inst} buffer.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int PC_WIDTH   = IF_PC_WIDTH,
    parameter int INST_WIDTH = IF_INST_WIDTH,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_en,
    input  logic [PC_WIDTH-1:0]   pc,
    input  logic                  br_taken,
    output logic                  pc_stall,
    if_fetch_unit_if.master       imem,
    output logic                  if_valid,
    output logic [PC_WIDTH-1:0]   if_pc,
    output logic [INST_WIDTH-1:0] if_inst,
    input  logic                  id_ready
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = PC_WIDTH + INST_WIDTH;

    if_state_e             state_q, state_d;
    logic [PC_WIDTH-1:0]   req_addr_q, req_addr_d;
    logic                  drop_q, drop_d;
    logic                  imem_req_q, imem_req_d;

    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      count_after;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [ENTRY_W-1:0]    fifo_din;
    logic [ENTRY_W-1:0]    fifo_dout;
    logic                  retire;
    logic                  issue;

    always_comb begin
        retire    = (state_q == IF_RSP) & imem.rvalid;
        fifo_push = retire & ~drop_q & ~br_taken;
        fifo_pop  = ~fifo_empty & id_ready & ~br_taken;
        // occupancy once this cycle settles; a new fetch needs a guaranteed free slot
        count_after = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        issue       = cpu_en & ~br_taken & (count_after < CNT_W'(FIFO_DEPTH));
        pc_stall    = ~(br_taken | ((state_q == IF_REQ) & imem.gnt & ~drop_q));

        state_d    = state_q;
        req_addr_d = req_addr_q;
        unique case (state_q)
            IF_IDLE: begin
                if (issue) begin
                    state_d    = IF_REQ;
                    req_addr_d = pc;
                end
            end
            IF_REQ: begin
                if (imem.gnt) begin
                    state_d = IF_RSP;
                end
            end
            IF_RSP: begin
                if (imem.rvalid) begin
                    if (issue) begin
                        state_d    = IF_REQ;
                        req_addr_d = pc;
                    end else begin
                        state_d = IF_IDLE;
                    end
                end
            end
            default: state_d = IF_IDLE;
        endcase

        // retiring clears the mark; a redirect on the retire cycle is handled by gating the push
        drop_d = drop_q;
        if (retire) begin
            drop_d = 1'b0;
        end else if (br_taken && (state_q != IF_IDLE)) begin
            drop_d = 1'b1;
        end

        imem_req_d = (state_d == IF_REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IF_IDLE;
            req_addr_q <= '0;
            drop_q     <= 1'b0;
            imem_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            drop_q     <= drop_d;
            imem_req_q <= imem_req_d;
        end
    end

    assign imem.req  = imem_req_q;
    assign imem.addr = req_addr_q;
    assign fifo_din  = {req_addr_q, imem.rdata};

    if_inst_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (br_taken),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign if_valid = ~fifo_empty;
    assign if_pc    = fifo_dout[ENTRY_W-1:INST_WIDTH];
    assign if_inst  = fifo_dout[INST_WIDTH-1:0];

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: acts as PC register and instruction memory, scores the decode stream.
module tb_if_fetch_unit;

    localparam int PW = 32;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_en;
    logic [PW-1:0] pc;
    logic          br_taken;
    logic [PW-1:0] br_addr;
    logic          pc_stall;
    logic          if_valid;
    logic [PW-1:0] if_pc;
    logic [IW-1:0] if_inst;
    logic          id_ready;

    if_fetch_unit_if #(.PC_WIDTH(PW), .INST_WIDTH(IW)) imem_bus ();

    if_fetch_unit #(
        .PC_WIDTH   (PW),
        .INST_WIDTH (IW),
        .FIFO_DEPTH (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_en   (cpu_en),
        .pc       (pc),
        .br_taken (br_taken),
        .pc_stall (pc_stall),
        .imem     (imem_bus),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .id_ready (id_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // memory slave state
    bit            pending, stray, rand_lat;
    int            wait_cnt, rv_cnt, gnt_lat, rv_lat;
    logic [PW-1:0] pend_addr;
    // reference model state
    bit            dead, prev_wait, gnt_seen, stall_s, br_s;
    logic [PW-1:0] prev_addr, exp_pc, fetch_ptr, br_addr_s;
    logic [PW-1:0] last_gnt_addr, last_any_gnt_addr;
    int            req_run, last_req_cycles, stall_low_cnt, live_gnts, pops;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h00500093 ^ (a * 32'h9E3779B9);
    endfunction

    task automatic mem_drive();
        if (rst) begin
            imem_bus.gnt    = 1'b0;
            imem_bus.rvalid = 1'b0;
            imem_bus.rdata  = '0;
        end else begin
            imem_bus.gnt    = imem_bus.req && (wait_cnt >= gnt_lat);
            imem_bus.rvalid = (pending && (rv_cnt >= rv_lat)) || stray;
            if (imem_bus.rvalid) imem_bus.rdata = stray ? 32'hDEADBEEF : memf(pend_addr);
            else                 imem_bus.rdata = $urandom;
        end
    endtask

    task automatic observe();
        stall_s   = pc_stall;
        br_s      = br_taken;
        br_addr_s = br_addr;
        if (rst) begin
            pending = 0; dead = 0; prev_wait = 0; wait_cnt = 0; rv_cnt = 0; req_run = 0;
            exp_pc = '0; fetch_ptr = '0;
            return;
        end
        if (!pc_stall) stall_low_cnt++;
        if (prev_wait) begin
            chk("req_hold", imem_bus.req, 1);
            chk("addr_hold", imem_bus.addr, prev_addr);
        end
        prev_wait = imem_bus.req && !imem_bus.gnt;
        prev_addr = imem_bus.addr;
        // decode side: the delivered stream is contiguous from the last redirect target
        if (!if_valid) begin
            chk("empty_pc", if_pc, 0);
            chk("empty_inst", if_inst, 0);
        end else if (id_ready && !br_taken) begin
            $display("pop pc=%08h inst=%08h", if_pc, if_inst);
            chk("pop_pc", if_pc, exp_pc);
            chk("pop_inst", if_inst, memf(exp_pc));
            exp_pc += 4;
            pops++;
        end
        if (br_taken) exp_pc = br_addr;
        // memory side
        if (imem_bus.rvalid && pending) begin
            pending = 0; dead = 0; rv_cnt = 0;
            if (rand_lat) rv_lat = $urandom_range(0, 3);
        end else begin
            if (br_taken && (imem_bus.req || pending)) dead = 1;
            if (pending) rv_cnt++;
        end
        if (imem_bus.req) begin
            req_run++;
            if (imem_bus.gnt) begin
                gnt_seen = 1; last_any_gnt_addr = imem_bus.addr;
                last_req_cycles = req_run; req_run = 0; wait_cnt = 0;
                pending = 1; rv_cnt = 0; pend_addr = imem_bus.addr;
                if (!dead) begin
                    chk("fetch_addr", imem_bus.addr, fetch_ptr);
                    fetch_ptr += 4;
                    last_gnt_addr = imem_bus.addr;
                    live_gnts++;
                end
                if (rand_lat) gnt_lat = $urandom_range(0, 3);
            end else begin
                wait_cnt++;
            end
        end
        if (br_taken) fetch_ptr = br_addr;
    endtask

    // one clock: drive memory at negedge, observe, edge, then update the PC register model
    task automatic tick();
        mem_drive();
        #1;
        observe();
        @(posedge clk);
        #1;
        if (rst)            pc = '0;
        else if (br_s)      pc = br_addr_s;
        else if (!stall_s)  pc = pc + 4;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; cpu_en = 0; br_taken = 0; id_ready = 0; stray = 0; br_addr = '0;
        gnt_lat = 0; rv_lat = 0;
        tick();
        tick();
        rst = 0;
        stall_low_cnt = 0; live_gnts = 0; pops = 0; gnt_seen = 0;
        last_gnt_addr = '1; last_any_gnt_addr = '1; last_req_cycles = 0;
    endtask

    task automatic wait_gnt(input int budget);
        gnt_seen = 0;
        for (int i = 0; i < budget && !gnt_seen; i++) tick();
        chk("gnt_seen", gnt_seen, 1);
    endtask

    initial begin
        rst = 1; cpu_en = 0; br_taken = 0; id_ready = 0; br_addr = '0; pc = '0;
        stray = 0; rand_lat = 0; gnt_lat = 0; rv_lat = 0;
        imem_bus.gnt = 0; imem_bus.rvalid = 0; imem_bus.rdata = '0;
        @(negedge clk);

        do_reset();
        chk("rst_req", imem_bus.req, 0);
        chk("rst_addr", imem_bus.addr, 0);
        chk("rst_valid", if_valid, 0);
        chk("rst_pc", if_pc, 0);
        chk("rst_inst", if_inst, 0);

        // single fetch, cpu_en dropped mid-fetch
        cpu_en = 1; tick(); cpu_en = 0;
        repeat (5) tick();
        chk("t1_addr", last_gnt_addr, 0);
        chk("t1_fetches", live_gnts, 1);
        chk("t1_stall_low", stall_low_cnt, 1);
        chk("t1_valid", if_valid, 1);
        chk("t1_pc", if_pc, 0);
        chk("t1_inst", if_inst, 32'h00500093);
        id_ready = 1; tick(); id_ready = 0;
        chk("t1_pops", pops, 1);

        // fill the buffer with decode stalled
        do_reset();
        cpu_en = 1;
        repeat (12) tick();
        chk("t2_req_idle", imem_bus.req, 0);
        chk("t2_pc_hold", pc, 32'h8);
        chk("t2_fetches", live_gnts, 2);
        chk("t2_head", if_pc, 0);
        stall_low_cnt = 0;
        repeat (3) tick();
        chk("t2_stalled", stall_low_cnt, 0);
        id_ready = 1; tick(); id_ready = 0;
        wait_gnt(10);
        chk("t2_next_addr", last_gnt_addr, 32'h8);

        // grant delayed three cycles
        do_reset();
        gnt_lat = 3; id_ready = 1; cpu_en = 1;
        wait_gnt(20);
        wait_gnt(20);
        chk("t3_addr", last_gnt_addr, 32'h4);
        chk("t3_req_cycles", last_req_cycles, 4);
        chk("t3_stall_low", stall_low_cnt, 2);

        // redirect between grant and response
        do_reset();
        rv_lat = 3; cpu_en = 1;
        wait_gnt(10);
        wait_gnt(20);
        chk("t4_addr4", last_gnt_addr, 32'h4);
        br_taken = 1; br_addr = 32'h100; tick(); br_taken = 0;
        wait_gnt(30);
        chk("t4_valid", if_valid, 0);
        chk("t4_next", last_any_gnt_addr, 32'h100);

        // redirect on the grant cycle
        do_reset();
        id_ready = 1; cpu_en = 1;
        wait_gnt(10);
        wait_gnt(10);
        tick();
        br_taken = 1; br_addr = 32'h200; tick(); br_taken = 0;
        chk("t5_gnt8", last_any_gnt_addr, 32'h8);
        chk("t5_pc", pc, 32'h200);
        wait_gnt(10);
        chk("t5_next", last_any_gnt_addr, 32'h200);

        // reset while waiting for data, then a stray rvalid
        do_reset();
        rv_lat = 5; cpu_en = 1;
        wait_gnt(10);
        tick();
        cpu_en = 0; rst = 1; tick(); rst = 0;
        stray = 1; tick(); stray = 0;
        repeat (2) tick();
        chk("t6_req", imem_bus.req, 0);
        chk("t6_valid", if_valid, 0);
        chk("t6_pc", if_pc, 0);

        // randomized traffic against the stream model
        do_reset();
        rand_lat = 1;
        for (int i = 0; i < 3000; i++) begin
            cpu_en   = ($urandom_range(0, 9) != 0);
            id_ready = ($urandom_range(0, 9) < 6);
            br_taken = ($urandom_range(0, 24) == 0);
            br_addr  = 32'h1000 + ($urandom_range(0, 1023) << 2);
            tick();
        end
        br_taken = 0; cpu_en = 0; id_ready = 1;
        repeat (30) tick();
        chk("drain_valid", if_valid, 0);
        chk("drain_req", imem_bus.req, 0);
        chk("rand_progress", pops > 100, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
